// File: rtl/ucode_store_if.sv
// Read-port and byte-programming-port signals of the microcode store.
// master = the uPC/programmer side, slave = the store itself.
interface ucode_store_if;
  // read port
  logic [7:0]  rd_addr;
  logic        rd_en;
  logic [23:0] rd_data;
  logic        rd_valid;
  // programming port
  logic        prog_en;
  logic        prog_start;
  logic [7:0]  prog_addr;
  logic [7:0]  prog_byte;
  logic        prog_valid;
  logic        prog_ready;
  logic [7:0]  prog_wptr;
  logic        prog_done;

  modport master (
    output rd_addr, rd_en, prog_en, prog_start, prog_addr, prog_byte, prog_valid,
    input  rd_data, rd_valid, prog_ready, prog_wptr, prog_done
  );

  modport slave (
    input  rd_addr, rd_en, prog_en, prog_start, prog_addr, prog_byte, prog_valid,
    output rd_data, rd_valid, prog_ready, prog_wptr, prog_done
  );
endinterface

// File: rtl/ucode_store.sv
// 256 x 24-bit microcode store. A registered read port feeds the CPU's
// microinstruction latch; a byte-serial port assembles little-endian 24-bit
// words (3 bytes each) and writes them at an auto-incrementing pointer.
// The array itself has no reset so that a CPU reset keeps the loaded ucode.
module ucode_store (
  input  logic         clk,
  input  logic         rst,   // synchronous, active-low
  ucode_store_if.slave bus
);

  localparam int AW    = 8;
  localparam int DW    = 24;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_e;

  // storage
  logic [DW-1:0] mem [0:DEPTH-1];

  // programming FSM state
  state_e        state_q, state_d;
  logic [15:0]   asm_q, asm_d;        // bytes 0 and 1 of the word in flight
  logic [AW-1:0] wptr_q, wptr_d;
  logic          done_q, done_d;

  // read port state
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  // memory write request from the FSM
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          prog_ready;
  logic          accept;
  logic          rd_fire;

  // Ready is withheld in the prog_start cycle so a byte presented alongside
  // the restart is never counted as accepted.
  always_comb begin
    prog_ready = bus.prog_en && !bus.prog_start && (state_q != IDLE);
    accept     = bus.prog_valid && prog_ready;
  end

  // Programming FSM next-state: byte assembly, pointer and done-flag update.
  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    wptr_d    = wptr_q;
    done_d    = done_q;
    mem_we    = 1'b0;
    mem_waddr = wptr_q;
    mem_wdata = {bus.prog_byte, asm_q};

    if (!bus.prog_en) begin
      // leaving programming mode drops any partial word; pointer/flag kept
      state_d = IDLE;
      asm_d   = '0;
    end else if (bus.prog_start) begin
      state_d = B0;
      asm_d   = '0;
      wptr_d  = bus.prog_addr;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = B0;
        B0: if (accept) begin
          asm_d[7:0] = bus.prog_byte;
          state_d    = B1;
        end
        B1: if (accept) begin
          asm_d[15:8] = bus.prog_byte;
          state_d     = B2;
        end
        B2: if (accept) begin
          mem_we  = 1'b1;
          wptr_d  = wptr_q + 8'd1;
          if (wptr_q == 8'hFF) done_d = 1'b1;
          asm_d   = '0;
          state_d = B0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read port next-state: the CPU latch is frozen while programming.
  // The array is sampled before this edge's write lands, so a same-edge
  // read of the written address returns the old word.
  always_comb begin
    rd_fire    = bus.rd_en && !bus.prog_en;
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? mem[bus.rd_addr] : rd_data_q;
  end

  // Control/output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      asm_q      <= '0;
      wptr_q     <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      wptr_q     <= wptr_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Array write; reset blocks it so a word completing under reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.prog_ready = prog_ready;
  assign bus.prog_wptr  = wptr_q;
  assign bus.prog_done  = done_q;

endmodule

// File: tb/tb_ucode_store.sv
// Directed bench for ucode_store: programming, wrap/done, restart mid-word,
// prog_en drop mid-word, valid gaps, read blocking and reset retention.
module tb_ucode_store;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  ucode_store_if bus ();

  ucode_store dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // advance one edge; inputs change and outputs are sampled 1 unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present one byte for one accepting cycle
  task automatic send_byte(input logic [7:0] b, input string tag);
    bus.prog_byte  = b;
    bus.prog_valid = 1'b1;
    #1;
    chk(tag, {31'd0, bus.prog_ready}, 32'd1);
    tick();
    bus.prog_valid = 1'b0;
  endtask

  task automatic send_word(input logic [23:0] w, input string tag);
    send_byte(w[7:0],   tag);
    send_byte(w[15:8],  tag);
    send_byte(w[23:16], tag);
  endtask

  task automatic start(input logic [7:0] a);
    bus.prog_start = 1'b1;
    bus.prog_addr  = a;
    tick();
    bus.prog_start = 1'b0;
  endtask

  // read one address with programming mode off and check the word
  task automatic rd(input logic [7:0] a, input logic [23:0] exp, input string tag);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_en = 1'b0;
    chk(tag, {8'd0, bus.rd_data}, {8'd0, exp});
    chk({tag, "_vld"}, {31'd0, bus.rd_valid}, 32'd1);
  endtask

  initial begin
    bus.rd_addr    = '0;
    bus.rd_en      = 1'b0;
    bus.prog_en    = 1'b0;
    bus.prog_start = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_byte  = '0;
    bus.prog_valid = 1'b0;

    // ---- reset state
    tick(); tick();
    chk("rst_rd_data",  {8'd0, bus.rd_data},     32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid},   32'd0);
    chk("rst_ready",    {31'd0, bus.prog_ready}, 32'd0);
    chk("rst_wptr",     {24'd0, bus.prog_wptr},  32'd0);
    chk("rst_done",     {31'd0, bus.prog_done},  32'd0);
    rst = 1'b1;

    // ---- basic program at 0x10, read blocked during programming
    bus.prog_en = 1'b1;
    #1;
    chk("idle_ready", {31'd0, bus.prog_ready}, 32'd0);
    tick();                                    // IDLE -> B0
    start(8'h10);
    chk("start_wptr", {24'd0, bus.prog_wptr}, 32'h10);
    send_word(24'h123456, "rdy_w10");
    chk("w10_wptr", {24'd0, bus.prog_wptr}, 32'h11);
    chk("w10_done", {31'd0, bus.prog_done}, 32'd0);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'h10;
    tick();
    chk("blk_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("blk_rd_data",  {8'd0, bus.rd_data},   32'd0);
    bus.rd_en   = 1'b0;
    bus.prog_en = 1'b0;
    rd(8'h10, 24'h123456, "rd_10");
    tick();
    chk("hold_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("hold_rd_data",  {8'd0, bus.rd_data},   32'h123456);

    // ---- wrap at 0xFF sets done; restart clears it
    bus.prog_en = 1'b1;
    tick();
    start(8'hFF);
    send_word(24'hCCBBAA, "rdy_wff");
    chk("wrap_wptr", {24'd0, bus.prog_wptr}, 32'h00);
    chk("wrap_done", {31'd0, bus.prog_done}, 32'd1);
    tick();
    chk("done_sticky", {31'd0, bus.prog_done}, 32'd1);

    // ---- restart after 2 bytes; byte with prog_start ignored
    start(8'h10);
    chk("restart_done", {31'd0, bus.prog_done}, 32'd0);
    send_byte(8'h77, "rdy_part");
    send_byte(8'h88, "rdy_part");
    bus.prog_start = 1'b1;
    bus.prog_addr  = 8'h20;
    bus.prog_byte  = 8'h99;
    bus.prog_valid = 1'b1;
    #1;
    chk("start_ready", {31'd0, bus.prog_ready}, 32'd0);
    tick();
    bus.prog_start = 1'b0;
    bus.prog_valid = 1'b0;
    chk("restart_wptr", {24'd0, bus.prog_wptr}, 32'h20);
    send_word(24'h030201, "rdy_w20");
    chk("w20_wptr", {24'd0, bus.prog_wptr}, 32'h21);

    // ---- prog_en drop mid-word discards partial, keeps pointer
    send_byte(8'hEE, "rdy_drop");
    bus.prog_en = 1'b0;
    tick();
    bus.prog_en = 1'b1;
    tick();
    chk("drop_wptr", {24'd0, bus.prog_wptr}, 32'h21);
    send_word(24'h332211, "rdy_w21");

    // ---- valid gaps: only valid cycles advance
    bus.prog_byte  = 8'h44; bus.prog_valid = 1'b1; tick();
    bus.prog_byte  = 8'h55; bus.prog_valid = 1'b0; tick();
    bus.prog_byte  = 8'h66; bus.prog_valid = 1'b1; tick();
    bus.prog_byte  = 8'h5A; bus.prog_valid = 1'b0; tick(); tick();
    chk("gap_wptr_mid", {24'd0, bus.prog_wptr}, 32'h22);
    bus.prog_byte  = 8'h77; bus.prog_valid = 1'b1; tick();
    bus.prog_valid = 1'b0;
    chk("gap_wptr", {24'd0, bus.prog_wptr}, 32'h23);

    bus.prog_en = 1'b0;
    rd(8'h10, 24'h123456, "rd_10_kept");
    rd(8'h20, 24'h030201, "rd_20");
    rd(8'hFF, 24'hCCBBAA, "rd_ff");
    rd(8'h21, 24'h332211, "rd_21");
    rd(8'h22, 24'h776644, "rd_22");

    // ---- reset mid-word and mid-read
    bus.prog_en = 1'b1;
    tick();
    send_byte(8'hAB, "rdy_rst");
    rst          = 1'b0;
    bus.rd_en    = 1'b1;
    bus.rd_addr  = 8'h10;
    tick();
    chk("rst2_rd_data",  {8'd0, bus.rd_data},     32'd0);
    chk("rst2_rd_valid", {31'd0, bus.rd_valid},   32'd0);
    chk("rst2_ready",    {31'd0, bus.prog_ready}, 32'd0);
    chk("rst2_wptr",     {24'd0, bus.prog_wptr},  32'd0);
    chk("rst2_done",     {31'd0, bus.prog_done},  32'd0);
    bus.rd_en   = 1'b0;
    bus.prog_en = 1'b0;
    rst = 1'b1;
    tick();
    rd(8'h10, 24'h123456, "rd_10_after_rst");
    rd(8'h22, 24'h776644, "rd_22_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ucode_store.md
UCODE_STORE -- requirements
Module: ucode_store

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state and memory.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: rd_addr  input  8  microinstruction address from the uPC.
REQ-004 SHALL have port: rd_en  input  1  read strobe (CPU latch clock-enable).
REQ-005 SHALL have port: rd_data  output  24  registered microinstruction word.
REQ-006 SHALL have port: rd_valid  output  1  one-cycle pulse marking a new rd_data.
REQ-007 SHALL have port: prog_en  input  1  programming mode; blocks the read port while high.
REQ-008 SHALL have port: prog_start  input  1  one-cycle pulse that loads the write pointer from prog_addr.
REQ-009 SHALL have port: prog_addr  input  8  start address for programming.
REQ-010 SHALL have port: prog_byte  input  8  programming data byte.
REQ-011 SHALL have port: prog_valid  input  1  prog_byte is valid.
REQ-012 SHALL have port: prog_ready  output  1  store accepts a byte this cycle.
REQ-013 SHALL have port: prog_wptr  output  8  current write pointer.
REQ-014 SHALL have port: prog_done  output  1  sticky flag; set when the write pointer wraps 255->0.

Function
REQ-015 SHALL hold a 256 x 24-bit storage array; reset SHALL NOT alter array contents.
REQ-016 SHALL implement the read port as follows: when rd_en=1 and prog_en=0 at a clock edge, rd_data <= mem[rd_addr] and rd_valid=1 in the following cycle. Latency is 1 cycle.
REQ-017 SHALL hold rd_data when no read occurs, and SHALL drive rd_valid=0 in that cycle.
REQ-018 SHALL ignore rd_en while prog_en=1: rd_valid=0 and rd_data is held.
REQ-019 SHALL implement the programming FSM with states IDLE, B0, B1, B2; prog_ready=1 only in B0/B1/B2 with prog_en=1.
REQ-020 SHALL transition IDLE->B0 when prog_en=1.
REQ-021 SHALL define a byte as accepted on any edge with prog_valid=1 and prog_ready=1. Acceptance transitions are B0->B1, B1->B2, B2->B0.
REQ-022 SHALL assemble bytes little-endian: the B0 byte goes to bits [7:0], the B1 byte to [15:8], and the B2 byte to [23:16].
REQ-023 SHALL, on byte acceptance in B2, write the assembled word to mem[prog_wptr] and then increment prog_wptr modulo 256.
REQ-024 SHALL, on increment from 255 to 0, set prog_done=1. prog_done stays 1 until reset or prog_start.
REQ-025 SHALL, on prog_start=1 with prog_en=1, set prog_wptr <= prog_addr, discard any partial word, enter B0, and clear prog_done. Any byte presented in the same cycle SHALL be ignored.
REQ-026 SHALL, when prog_en falls, go to IDLE and discard any partial word; prog_wptr and prog_done are retained.
REQ-027 SHALL hold FSM state when prog_valid=0; no timeout applies.
REQ-028 SHALL be write-first-invisible: a read of an address in the same cycle as its write returns the old contents. Reads are blocked during programming, so this case arises only across a prog_en edge.

Reset
REQ-029 SHALL, while rst=0 at a clock edge, set rd_data=24'h000000, rd_valid=0, FSM=IDLE, prog_ready=0, prog_wptr=8'h00, prog_done=0, and clear the assembly register.
REQ-030 SHALL give reset priority over all other inputs, including reset asserted mid-word or mid-read. A partial word SHALL NOT be written.

Verification
REQ-031 SHALL be verified with this scenario: prog_en=1, prog_start with prog_addr=8'h10, then bytes 8'h56, 8'h34, 8'h12 -> mem[8'h10]=24'h123456 and prog_wptr=8'h11. Then prog_en=0, rd_en=1, rd_addr=8'h10 -> next cycle rd_data=24'h123456, rd_valid=1.
REQ-032 SHALL be verified with this scenario: prog_start with prog_addr=8'hFF, then 3 bytes AA,BB,CC -> mem[8'hFF]=24'hCCBBAA, prog_wptr=8'h00, prog_done=1. A subsequent prog_start clears prog_done.
REQ-033 SHALL be verified with this scenario: after 2 bytes have been accepted, pulse prog_start with prog_addr=8'h20, then send 01,02,03 -> mem[8'h20]=24'h030201 and no write to the prior address.
REQ-034 SHALL be verified with this scenario: rd_en=1 with prog_en=1 -> rd_valid stays 0 and rd_data is unchanged. With prog_valid toggling 1/0/1, only the 1-cycles with prog_ready=1 advance the FSM.
REQ-035 SHALL be verified with this scenario: rst=0 asserted after 1 byte, then released, then a read of a previously programmed address -> outputs at their reset values, prog_wptr=0, and the old memory word is still returned intact.
